// File: rtl/tds_trace_capture.sv
// Delay-line trace capture: synchronizes taps and trigger, snapshots the taps on a trigger
// rising edge, emits the snapshot with its popcount, then optionally holds off before re-arming.
module tds_trace_capture #(
    parameter int WIDTH          = 64,
    parameter int HOLDOFF_CYCLES = 76800,
    parameter bit CONTINUOUS     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           delay_taps,
    input  logic                       trigger,
    input  logic                       arm,
    input  logic                       downstream_full,
    output logic [WIDTH-1:0]           trace_out,
    output logic                       trace_valid,
    output logic [$clog2(WIDTH):0]     trace_ones,
    output logic                       busy,
    output logic [15:0]                capture_count,
    output logic [15:0]                drop_count
);

    localparam int OW = $clog2(WIDTH) + 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_EMIT,
        S_HOLDOFF
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  taps_s1_q, taps_s1_d;
    logic [WIDTH-1:0]  taps_s2_q, taps_s2_d;
    logic              trig_s1_q, trig_s1_d;
    logic              trig_s2_q, trig_s2_d;
    logic              trig_s3_q, trig_s3_d;
    logic [WIDTH-1:0]  snap_q, snap_d;
    logic [WIDTH-1:0]  trace_out_q, trace_out_d;
    logic [OW-1:0]     trace_ones_q, trace_ones_d;
    logic              trace_valid_q, trace_valid_d;
    logic [15:0]       capture_count_q, capture_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic [HW-1:0]     holdoff_cnt_q, holdoff_cnt_d;
    logic              need_rearm_q, need_rearm_d;

    logic              trig_rise;
    logic              holdoff_done;

    function automatic logic [OW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + OW'(v[i]);
        end
        return n;
    endfunction

    // The third trigger flop always tracks, so a trigger that is already high when the
    // detector starts listening never looks like a fresh edge.
    assign trig_rise    = trig_s2_q & ~trig_s3_q;
    assign holdoff_done = (32'(holdoff_cnt_q) == 32'(HOLDOFF_CYCLES - 1));

    always_comb begin
        taps_s1_d       = delay_taps;
        taps_s2_d       = taps_s1_q;
        trig_s1_d       = trigger;
        trig_s2_d       = trig_s1_q;
        trig_s3_d       = trig_s2_q;
        state_d         = state_q;
        snap_d          = snap_q;
        trace_out_d     = trace_out_q;
        trace_ones_d    = trace_ones_q;
        trace_valid_d   = 1'b0;
        capture_count_d = capture_count_q;
        drop_count_d    = drop_count_q;
        holdoff_cnt_d   = holdoff_cnt_q;
        need_rearm_d    = arm ? need_rearm_q : 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm && !need_rearm_q) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (trig_rise) begin
                    state_d = S_CAPTURE;
                    snap_d  = taps_s2_q;
                end
            end
            S_CAPTURE: begin
                trace_out_d  = snap_q;
                trace_ones_d = popcount(snap_q);
                state_d      = S_EMIT;
            end
            S_EMIT: begin
                if (!downstream_full) begin
                    trace_valid_d = 1'b1;
                    if (capture_count_q != 16'hFFFF) begin
                        capture_count_d = capture_count_q + 16'd1;
                    end
                end else if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
                holdoff_cnt_d = '0;
                // Single-shot waits for software to drop and re-raise arm.
                if (!CONTINUOUS) begin
                    state_d      = S_IDLE;
                    need_rearm_d = 1'b1;
                end else if (HOLDOFF_CYCLES == 0) begin
                    state_d = arm ? S_ARMED : S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (holdoff_done) begin
                    state_d = S_ARMED;
                end else begin
                    holdoff_cnt_d = holdoff_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            taps_s1_q       <= '0;
            taps_s2_q       <= '0;
            trig_s1_q       <= 1'b0;
            trig_s2_q       <= 1'b0;
            trig_s3_q       <= 1'b0;
            snap_q          <= '0;
            trace_out_q     <= '0;
            trace_ones_q    <= '0;
            trace_valid_q   <= 1'b0;
            capture_count_q <= '0;
            drop_count_q    <= '0;
            holdoff_cnt_q   <= '0;
            need_rearm_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            taps_s1_q       <= taps_s1_d;
            taps_s2_q       <= taps_s2_d;
            trig_s1_q       <= trig_s1_d;
            trig_s2_q       <= trig_s2_d;
            trig_s3_q       <= trig_s3_d;
            snap_q          <= snap_d;
            trace_out_q     <= trace_out_d;
            trace_ones_q    <= trace_ones_d;
            trace_valid_q   <= trace_valid_d;
            capture_count_q <= capture_count_d;
            drop_count_q    <= drop_count_d;
            holdoff_cnt_q   <= holdoff_cnt_d;
            need_rearm_q    <= need_rearm_d;
        end
    end

    assign trace_out     = trace_out_q;
    assign trace_ones    = trace_ones_q;
    assign trace_valid   = trace_valid_q;
    assign capture_count = capture_count_q;
    assign drop_count    = drop_count_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_ARMED);

endmodule

// File: tb/tb_tds_trace_capture.sv
// Bench for tds_trace_capture: a continuous and a single-shot instance share stimulus and are
// checked every cycle against an event-timeline model, plus hand-computed expectations.
module tb_tds_trace_capture;

    localparam int W  = 64;
    localparam int H  = 16;
    localparam int OW = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] delay_taps = '0;
    logic         trigger = 1'b0;
    logic         arm = 1'b0;
    logic         downstream_full = 1'b0;

    logic [W-1:0]  trace_out     [2];
    logic          trace_valid   [2];
    logic [OW-1:0] trace_ones    [2];
    logic          busy          [2];
    logic [15:0]   capture_count [2];
    logic [15:0]   drop_count    [2];

    tds_trace_capture #(.WIDTH(W), .HOLDOFF_CYCLES(H), .CONTINUOUS(1'b1)) u_dut_cont (
        .clk(clk), .rst(rst), .delay_taps(delay_taps), .trigger(trigger), .arm(arm),
        .downstream_full(downstream_full), .trace_out(trace_out[0]), .trace_valid(trace_valid[0]),
        .trace_ones(trace_ones[0]), .busy(busy[0]), .capture_count(capture_count[0]),
        .drop_count(drop_count[0])
    );

    tds_trace_capture #(.WIDTH(W), .HOLDOFF_CYCLES(H), .CONTINUOUS(1'b0)) u_dut_single (
        .clk(clk), .rst(rst), .delay_taps(delay_taps), .trigger(trigger), .arm(arm),
        .downstream_full(downstream_full), .trace_out(trace_out[1]), .trace_valid(trace_valid[1]),
        .trace_ones(trace_ones[1]), .busy(busy[1]), .capture_count(capture_count[1]),
        .drop_count(drop_count[1])
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int valid_seen [2] = '{0, 0};
    string inst_name [2] = '{"cont", "single"};

    // Model: input history by edge number, plus per-instance timeline of the current capture.
    logic         trig_h [8];
    logic [W-1:0] taps_h [8];
    bit           m_cont    [2] = '{1'b1, 1'b0};
    bit           m_listen  [2];
    bit           m_engaged [2];
    bit           m_need    [2];
    int           m_k       [2];
    int           m_emit    [2];
    int           m_hold_end[2];
    logic [W-1:0] m_out     [2];
    logic [OW-1:0] m_ones   [2];
    bit           m_valid   [2];
    bit           m_busy    [2];
    int           m_cap     [2];
    int           m_drop    [2];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) begin
            trig_h[j] = 1'b0;
            taps_h[j] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            m_listen[i] = 0; m_engaged[i] = 0; m_need[i] = 0;
            m_out[i] = '0; m_ones[i] = '0; m_valid[i] = 0; m_busy[i] = 0;
            m_cap[i] = 0; m_drop[i] = 0;
        end
    endtask

    // Rising edge registered at edge k is acted on at edge k+2, the snapshot appears at k+3,
    // the strobe/counters at k+4, then H holdoff cycles in continuous mode.
    task automatic model_step(input int i);
        bit single_emit;
        single_emit = 0;
        m_valid[i] = 0;
        if (m_engaged[i]) begin
            if (cyc == m_emit[i] - 1) begin
                m_out[i]  = taps_h[m_k[i] % 8];
                m_ones[i] = OW'($countones(taps_h[m_k[i] % 8]));
            end else if (cyc == m_emit[i]) begin
                if (!downstream_full) begin
                    m_valid[i] = 1;
                    if (m_cap[i] < 65535) m_cap[i]++;
                end else if (m_drop[i] < 65535) begin
                    m_drop[i]++;
                end
                if (!m_cont[i]) begin
                    m_engaged[i] = 0;
                    m_listen[i]  = 0;
                    single_emit  = 1;
                end else begin
                    m_hold_end[i] = cyc + H;
                end
            end else if (cyc > m_emit[i]) begin
                if (!arm) begin
                    m_engaged[i] = 0;
                    m_listen[i]  = 0;
                end else if (cyc == m_hold_end[i]) begin
                    m_engaged[i] = 0;
                    m_listen[i]  = 1;
                end
            end
        end else if (m_listen[i]) begin
            if (!arm) begin
                m_listen[i] = 0;
            end else if (trig_h[(cyc - 2) % 8] && !trig_h[(cyc - 3) % 8]) begin
                m_engaged[i] = 1;
                m_listen[i]  = 0;
                m_k[i]       = cyc - 2;
                m_emit[i]    = cyc + 2;
            end
        end else if (arm && !m_need[i]) begin
            m_listen[i] = 1;
        end
        if (single_emit) m_need[i] = 1;
        else if (!arm) m_need[i] = 0;
        m_busy[i] = m_engaged[i];
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            trig_h[cyc % 8] = trigger;
            taps_h[cyc % 8] = delay_taps;
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (trace_valid[i]) valid_seen[i]++;
            check_output({inst_name[i], " trace_valid"}, 64'(trace_valid[i]), 64'(m_valid[i]));
            check_output({inst_name[i], " trace_out"}, trace_out[i], m_out[i]);
            check_output({inst_name[i], " trace_ones"}, 64'(trace_ones[i]), 64'(m_ones[i]));
            check_output({inst_name[i], " busy"}, 64'(busy[i]), 64'(m_busy[i]));
            check_output({inst_name[i], " capture_count"}, 64'(capture_count[i]), 64'(m_cap[i]));
            check_output({inst_name[i], " drop_count"}, 64'(drop_count[i]), 64'(m_drop[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic a, input logic t, input logic f, input logic [W-1:0] taps);
        arm             = a;
        trigger         = t;
        downstream_full = f;
        delay_taps      = taps;
    endtask

    int k;
    int got;
    int base_cap [2];
    int base_valid [2];

    initial begin
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check_output("reset trace_out", trace_out[0], 64'h0);
        check_output("reset trace_ones", 64'(trace_ones[0]), 64'd0);
        check_output("reset busy", 64'(busy[0]), 64'd0);
        check_output("reset capture_count", 64'(capture_count[0]), 64'd0);

        // Basic capture and k+4 latency.
        arm = 1'b1;
        step(3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0000_00FF_FFFF_FFFF);
        k = cyc + 1;
        step(1);
        delay_taps = 64'hDEAD_BEEF_0123_4567;
        got = -1;
        for (int n = 0; n < 10; n++) begin
            if (trace_valid[0]) begin
                got = cyc;
                break;
            end
            step(1);
        end
        check_output("valid latency", 64'(got), 64'(k + 4));
        check_output("capture trace_out", trace_out[0], 64'h0000_00FF_FFFF_FFFF);
        check_output("capture trace_ones", 64'(trace_ones[0]), 64'd40);
        check_output("capture count cont", 64'(capture_count[0]), 64'd1);
        check_output("capture count single", 64'(capture_count[1]), 64'd1);
        step(2);
        trigger = 1'b0;
        step(25);

        // Drop while downstream is full.
        arm = 1'b0;
        step(2);
        arm = 1'b1;
        step(3);
        base_valid[0] = valid_seen[0];
        base_valid[1] = valid_seen[1];
        apply_stimulus(1'b1, 1'b1, 1'b1, 64'hF0F0_F0F0_0000_0001);
        step(1);
        trigger = 1'b0;
        step(7);
        downstream_full = 1'b0;
        check_output("drop count cont", 64'(drop_count[0]), 64'd1);
        check_output("drop count single", 64'(drop_count[1]), 64'd1);
        check_output("drop keeps capture count", 64'(capture_count[0]), 64'd1);
        check_output("drop trace_out updates", trace_out[0], 64'hF0F0_F0F0_0000_0001);
        check_output("drop no strobe", 64'(valid_seen[0] - base_valid[0]), 64'd0);
        step(20);

        // Triggers 5 cycles apart: only the first and the one after holdoff are taken.
        base_cap[0] = capture_count[0];
        base_cap[1] = capture_count[1];
        delay_taps  = 64'h0123_4567_89AB_CDEF;
        for (int j = 0; j < 8; j++) begin
            trigger = 1'b1;
            step(2);
            trigger = 1'b0;
            step(3);
        end
        step(10);
        check_output("holdoff captures cont", 64'(capture_count[0] - base_cap[0]), 64'd2);
        check_output("single-shot no rearm", 64'(capture_count[1] - base_cap[1]), 64'd0);

        // Single-shot re-arms after arm toggles.
        arm = 1'b0;
        step(2);
        arm = 1'b1;
        step(3);
        trigger = 1'b1;
        step(2);
        trigger = 1'b0;
        step(8);
        check_output("single-shot rearmed", 64'(capture_count[1] - base_cap[1]), 64'd1);

        // Trigger already high when arm rises is not an edge.
        base_cap[0] = capture_count[0];
        base_cap[1] = capture_count[1];
        arm     = 1'b0;
        trigger = 1'b1;
        step(3);
        arm = 1'b1;
        step(10);
        check_output("level trigger ignored", 64'(capture_count[1] - base_cap[1]), 64'd0);
        trigger = 1'b0;
        step(2);
        trigger = 1'b1;
        step(8);
        trigger = 1'b0;
        check_output("fresh edge captured", 64'(capture_count[1] - base_cap[1]), 64'd1);
        check_output("fresh edge captured cont", 64'(capture_count[0] - base_cap[0]), 64'd1);
        step(20);

        // Reset one cycle after the trigger edge discards the capture.
        apply_stimulus(1'b1, 1'b1, 1'b0, 64'h1234_5678_0000_FFFF);
        step(1);
        rst     = 1'b1;
        trigger = 1'b0;
        arm     = 1'b0;
        step(1);
        rst = 1'b0;
        base_valid[0] = valid_seen[0];
        base_valid[1] = valid_seen[1];
        step(8);
        check_output("reset aborts strobe", 64'(valid_seen[0] - base_valid[0] + valid_seen[1] - base_valid[1]), 64'd0);
        check_output("reset aborts trace_out", trace_out[0], 64'h0);
        check_output("reset aborts count", 64'(capture_count[0]), 64'd0);
        check_output("reset aborts busy", 64'(busy[0]), 64'd0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/tds_trace_capture.md
TDS_TRACE_CAPTURE -- requirements
Module: tds_trace_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 64: number of delay-line taps.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 76800: minimum clk cycles between captures in continuous mode (one 8-byte UART line at 250 kbaud, 240 MHz).
REQ-003 SHALL have parameter CONTINUOUS, default 1: 1 = re-arm after holdoff, 0 = single-shot.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port delay_taps, input, WIDTH: raw delay-line tap outputs, asynchronous to clk.
REQ-007 SHALL have port trigger, input, 1: hit/start event, asynchronous to clk.
REQ-008 SHALL have port arm, input, 1: level; capture is enabled while high.
REQ-009 SHALL have port downstream_full, input, 1: downstream FIFO full (trace FIFO full flag).
REQ-010 SHALL have port trace_out, output, WIDTH: captured tap snapshot.
REQ-011 SHALL have port trace_valid, output, 1: one-cycle write strobe for trace_out.
REQ-012 SHALL have port trace_ones, output, $clog2(WIDTH)+1: population count of trace_out.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE or ARMED.
REQ-014 SHALL have port capture_count, output, 16: emitted traces (saturating).
REQ-015 SHALL have port drop_count, output, 16: captures discarded due to downstream_full (saturating).

Function
REQ-016 SHALL pass delay_taps and trigger through two-flop synchronizers (taps_s1/s2, trig_s1/s2), plus one extra trigger flop for rising-edge detect.
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, EMIT, HOLDOFF.
REQ-018 IDLE -> ARMED when arm=1; ARMED -> IDLE when arm=0.
REQ-019 ARMED -> CAPTURE on a synchronized trigger rising edge; a level-high trigger at arming is not an edge.
REQ-020 CAPTURE SHALL latch the tap snapshot aligned with the trigger: trace_out = delay_taps value registered at the same clk edge that first registered trigger=1 (edge k).
REQ-021 CAPTURE SHALL compute trace_ones from the latched snapshot; EMIT presents both together.
REQ-022 In EMIT, if downstream_full=0: trace_valid=1 for exactly one cycle, at edge k+4; capture_count += 1.
REQ-023 In EMIT, if downstream_full=1: trace_valid stays 0; drop_count += 1; trace_out still updates.
REQ-024 After EMIT: CONTINUOUS=1 -> HOLDOFF; CONTINUOUS=0 -> IDLE (software re-arms with arm 0->1).
REQ-025 HOLDOFF SHALL count HOLDOFF_CYCLES cycles, then go to ARMED if arm=1, else IDLE; HOLDOFF_CYCLES=0 -> direct to ARMED/IDLE.
REQ-026 Triggers during CAPTURE, EMIT, HOLDOFF are ignored and not counted.
REQ-027 arm falling during CAPTURE/EMIT SHALL NOT abort the in-flight capture; during HOLDOFF it SHALL go to IDLE next cycle.
REQ-028 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-029 trace_out and trace_ones SHALL hold value between captures.

Reset
REQ-030 On rst: state IDLE; trace_out=0, trace_ones=0, trace_valid=0, busy=0, capture_count=0, drop_count=0; synchronizer flops and holdoff counter cleared.
REQ-031 rst mid-capture or mid-holdoff SHALL discard the capture with no trace_valid pulse.

Verification
REQ-032 arm=1, taps=64'h0000_00FF_FFFF_FFFF, trigger rises at edge k -> trace_valid at k+4, trace_out=that value, trace_ones=40, capture_count=1.
REQ-033 downstream_full=1 during EMIT -> no trace_valid, drop_count=1, capture_count unchanged.
REQ-034 CONTINUOUS=1, HOLDOFF_CYCLES=16, triggers 5 cycles apart -> only 1st and every trigger after holdoff emit; intermediate ignored.
REQ-035 CONTINUOUS=0 -> second trigger gives no trace_valid until arm toggles 0->1.
REQ-036 trigger already high when arm rises -> no capture until trigger falls and rises again.
REQ-037 rst asserted one cycle after trigger edge -> no trace_valid, all outputs 0.
